tl_frontend: RTL and testbench
==============================

TL_FRONTEND -- requirements
Module: tl_frontend

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000; board clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1; slow_clk frequency in Hz.
REQ-003 Parameter DEBOUNCE_MS, default 20; required stable time of the button, in ms.
REQ-004 Parameter AUTO_START_TICKS, default 3; slow_clk periods before auto-start (used only under REQ-025).
REQ-005 Port clk, input, 1; board clock, all logic on its rising edge.
REQ-006 Port rst_n, input, 1; reset, synchronous and active-low.
REQ-007 Port btn_n, input, 1; raw asynchronous pushbutton, low = pressed.
REQ-008 Port slow_clk, output, 1; 50 % duty square wave at TICK_HZ, drives the clk of the traffic light controller.
REQ-009 Port tick, output, 1; one clk-cycle pulse per slow_clk period.
REQ-010 Port start, output, 1; level, 1 = normal cycling, 0 = blinking-yellow mode, drives the controller start input.
REQ-011 Port press, output, 1; one clk-cycle pulse per accepted debounced press.

Function
REQ-012 Prescaler: counter counts 0..HALF-1, HALF = CLK_FREQ_HZ/(2*TICK_HZ), width $clog2(HALF); it wraps to 0 after HALF-1.
REQ-013 slow_clk toggles on the clk edge where the prescaler wraps; first toggle (0->1) occurs HALF cycles after rst_n release.
REQ-014 tick is high for exactly the one clk cycle in which slow_clk is registered 0->1; never on 1->0.
REQ-015 btn_n passes a 2-flop synchroniser before any use; the synchronised value is btn_s.
REQ-016 Debounce FSM states: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE; DB_CYCLES = CLK_FREQ_HZ/1000*DEBOUNCE_MS.
REQ-017 Transition RELEASED->WAIT_PRESS when btn_s=0, clearing the debounce counter.
REQ-018 In WAIT_PRESS: if btn_s returns to 1 -> RELEASED; if the counter reaches DB_CYCLES-1 with btn_s=0 -> PRESSED and press pulses for 1 cycle.
REQ-019 Transition PRESSED->WAIT_RELEASE when btn_s=1, clearing the counter.
REQ-020 In WAIT_RELEASE: if btn_s returns to 0 -> PRESSED; if the counter reaches DB_CYCLES-1 with btn_s=1 -> RELEASED.
REQ-021 Each press pulse toggles start on the following clk edge; exactly one toggle per accepted press, regardless of hold time.
REQ-022 Bounces shorter than DB_CYCLES in either direction produce no press and no start change.
REQ-023 press coincident with tick: both occur; start toggles and the prescaler is unaffected.

Reset
REQ-024 While rst_n=0 at a clk edge: prescaler=0, slow_clk=0, tick=0, press=0, FSM=RELEASED, debounce counter=0, synchroniser flops=1, start=0, auto-start tick counter=0; a reset asserted mid-period or mid-debounce discards all progress.

Configuration
REQ-025 With macro TL_AUTO_START_EN defined: start is set to 1 on the clk edge of the AUTO_START_TICKS-th tick after reset, once only, unless a press has already occurred (a press cancels auto-start); without the macro, start changes only via press and no tick counter exists.

Verification
REQ-026 CLK_FREQ_HZ=1000, TICK_HZ=1, release reset -> slow_clk rises at cycle 500, falls at 1000, tick high only at cycles 500, 1500, 2500.
REQ-027 DEBOUNCE_MS=20 at 1000 Hz (DB_CYCLES=20); hold btn_n=0 for 100 cycles -> single press pulse, at about 2+20 cycles after the falling edge; start toggles 0->1 on the next edge.
REQ-028 btn_n glitches low for 10 cycles, 5 times -> no press, start stays 0.
REQ-029 Press, release with 8-cycle bounces, press again -> exactly two press pulses, start returns to 0.
REQ-030 Assert rst_n=0 for 1 cycle at prescaler=300 while in WAIT_PRESS -> all outputs 0, next slow_clk rise 500 cycles after release, no press.
REQ-031 TL_AUTO_START_EN, AUTO_START_TICKS=3, no button -> start rises at the 3rd tick (cycle 2500); repeat with a press before cycle 2500 -> start=1 from the press and no later change.

Source files
------------

// File: rtl/tl_frontend.sv
// Traffic-light front end: slow-clock prescaler, debounced start/stop button.
// Optional build macro TL_AUTO_START_EN enables a one-shot auto-start after reset.
module tl_frontend #(
    parameter int unsigned CLK_FREQ_HZ      = 50000000,
    parameter int unsigned TICK_HZ          = 1,
    parameter int unsigned DEBOUNCE_MS      = 20,
    parameter int unsigned AUTO_START_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic slow_clk,
    output logic tick,
    output logic start,
    output logic press
);

    localparam int unsigned HALF      = CLK_FREQ_HZ / (2 * TICK_HZ);
    localparam int unsigned PW        = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned DB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    // Reject degenerate configurations at elaboration time.
    if (HALF < 1 || DB_CYCLES < 1 || AUTO_START_TICKS < 1) begin : g_param_check
        $error("tl_frontend: HALF, DB_CYCLES and AUTO_START_TICKS must all be at least 1");
    end

    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } db_state_t;

    logic [PW-1:0] presc;
    logic          wrap_c;
    logic          rise_c;
    logic [1:0]    sync;
    logic          btn_s;
    db_state_t     db_state;
    logic [DW-1:0] db_cnt;
    logic          db_done_c;

    assign wrap_c    = (presc == PW'(HALF - 1));
    assign rise_c    = wrap_c & ~slow_clk;
    assign btn_s     = sync[1];
    assign db_done_c = (db_cnt == DW'(DB_CYCLES - 1));

    // Prescaler and slow clock; tick marks only the rising half.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            slow_clk <= 1'b0;
            tick     <= 1'b0;
        end else begin
            presc    <= wrap_c ? '0 : presc + PW'(1);
            slow_clk <= slow_clk ^ wrap_c;
            tick     <= rise_c;
        end
    end

    // Two-flop synchroniser, idles at the released level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], btn_n};
        end
    end

    // Debounce FSM: a level must hold for DB_CYCLES before it is believed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_state <= RELEASED;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            case (db_state)
                RELEASED: begin
                    if (!btn_s) begin
                        db_state <= WAIT_PRESS;
                        db_cnt   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (btn_s) begin
                        db_state <= RELEASED;
                    end else if (db_done_c) begin
                        db_state <= PRESSED;
                        press    <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (btn_s) begin
                        db_state <= WAIT_RELEASE;
                        db_cnt   <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (!btn_s) begin
                        db_state <= PRESSED;
                    end else if (db_done_c) begin
                        db_state <= RELEASED;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: begin
                    db_state <= RELEASED;
                    db_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef TL_AUTO_START_EN
    localparam int unsigned ACW = (AUTO_START_TICKS > 1) ? $clog2(AUTO_START_TICKS + 1) : 1;

    logic [ACW-1:0] auto_cnt;
    logic           auto_armed;

    // Start toggles on press; otherwise one-shot set on the Nth tick. Any press disarms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start      <= 1'b0;
            auto_cnt   <= '0;
            auto_armed <= 1'b1;
        end else if (press) begin
            start      <= ~start;
            auto_armed <= 1'b0;
        end else if (auto_armed && rise_c) begin
            if (auto_cnt == ACW'(AUTO_START_TICKS - 1)) begin
                start      <= 1'b1;
                auto_armed <= 1'b0;
            end else begin
                auto_cnt <= auto_cnt + ACW'(1);
            end
        end
    end
`else
    // Start mode flips once per accepted press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start <= 1'b0;
        end else if (press) begin
            start <= ~start;
        end
    end
`endif

endmodule

// File: tb/tb_tl_frontend.sv
// Directed bench for tl_frontend at 1 kHz clock, 1 Hz tick, 20-cycle debounce.
`timescale 1ns/1ps
module tb_tl_frontend;

    logic clk;
    logic rst_n;
    logic btn_n;
    logic slow_clk;
    logic tick;
    logic start;
    logic press;

    int tests;
    int fails;

    tl_frontend #(
        .CLK_FREQ_HZ     (1000),
        .TICK_HZ         (1),
        .DEBOUNCE_MS     (20),
        .AUTO_START_TICKS(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (btn_n),
        .slow_clk(slow_clk),
        .tick    (tick),
        .start   (start),
        .press   (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset two cycles; on return the next posedge is cycle 1 after release.
    task automatic apply_reset();
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (slow_clk !== 1'b0) begin fails++; $display("FAIL reset_slow_clk: got %b expected 0", slow_clk); end
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", tick); end
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", start); end
        tests++; if (press !== 1'b0) begin fails++; $display("FAIL reset_press: got %b expected 0", press); end
    endtask

    task automatic test_prescaler();
        int rise_at, fall_at, tick_cnt, start_at, press_cnt;
        int tick_at[3];
        logic prev;
        bit exp_start;
        int exp_start_at;
        rise_at = -1; fall_at = -1; tick_cnt = 0; start_at = -1; press_cnt = 0;
        tick_at = '{-1, -1, -1};
        apply_reset();
        prev = 1'b0;
        for (int n = 1; n <= 2600; n++) begin
            @(posedge clk); #1;
            if (slow_clk && !prev && rise_at < 0) rise_at = n;
            if (!slow_clk && prev && fall_at < 0) fall_at = n;
            if (tick) begin
                if (tick_cnt < 3) tick_at[tick_cnt] = n;
                tick_cnt++;
            end
            if (press) press_cnt++;
            if (start && start_at < 0) start_at = n;
            prev = slow_clk;
        end
`ifdef TL_AUTO_START_EN
        exp_start = 1'b1; exp_start_at = 2500;
`else
        exp_start = 1'b0; exp_start_at = -1;
`endif
        tests++; if (rise_at !== 500) begin fails++; $display("FAIL presc_rise: got %0d expected 500", rise_at); end
        tests++; if (fall_at !== 1000) begin fails++; $display("FAIL presc_fall: got %0d expected 1000", fall_at); end
        tests++; if (tick_cnt !== 3) begin fails++; $display("FAIL tick_count: got %0d expected 3", tick_cnt); end
        tests++; if (tick_at[0] !== 500) begin fails++; $display("FAIL tick0_cycle: got %0d expected 500", tick_at[0]); end
        tests++; if (tick_at[1] !== 1500) begin fails++; $display("FAIL tick1_cycle: got %0d expected 1500", tick_at[1]); end
        tests++; if (tick_at[2] !== 2500) begin fails++; $display("FAIL tick2_cycle: got %0d expected 2500", tick_at[2]); end
        tests++; if (press_cnt !== 0) begin fails++; $display("FAIL presc_no_press: got %0d expected 0", press_cnt); end
        tests++; if (start !== exp_start) begin fails++; $display("FAIL presc_start: got %b expected %b", start, exp_start); end
        tests++; if (start_at !== exp_start_at) begin fails++; $display("FAIL start_rise_cycle: got %0d expected %0d", start_at, exp_start_at); end
    endtask

    task automatic test_press();
        int press_at, press_cnt, start_at, start_changes;
        logic prev_start;
        press_at = -1; press_cnt = 0; start_at = -1; start_changes = 0;
        apply_reset();
        repeat (10) @(posedge clk);
        #1;
        btn_n = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (press) begin
                if (press_at < 0) press_at = n;
                press_cnt++;
            end
            if (start && start_at < 0) start_at = n;
        end
        btn_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (press) press_cnt++;
        end
        tests++; if (press_at !== 23) begin fails++; $display("FAIL press_latency: got %0d expected 23", press_at); end
        tests++; if (start_at !== 24) begin fails++; $display("FAIL start_toggle_cycle: got %0d expected 24", start_at); end
        tests++; if (press_cnt !== 1) begin fails++; $display("FAIL press_single: got %0d expected 1", press_cnt); end
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL press_start_level: got %b expected 1", start); end
`ifdef TL_AUTO_START_EN
        prev_start = start;
        for (int n = 1; n <= 2500; n++) begin
            @(posedge clk); #1;
            if (start !== prev_start) start_changes++;
            prev_start = start;
        end
        tests++; if (start_changes !== 0) begin fails++; $display("FAIL auto_cancel_changes: got %0d expected 0", start_changes); end
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL auto_cancel_start: got %b expected 1", start); end
`endif
    endtask

    task automatic test_glitch();
        int press_cnt;
        press_cnt = 0;
        apply_reset();
        repeat (5) begin
            btn_n = 1'b0;
            for (int n = 0; n < 10; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
            btn_n = 1'b1;
            for (int n = 0; n < 10; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
        end
        for (int n = 0; n < 30; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
        tests++; if (press_cnt !== 0) begin fails++; $display("FAIL glitch_press: got %0d expected 0", press_cnt); end
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL glitch_start: got %b expected 0", start); end
    endtask

    task automatic test_bounce();
        int press_cnt, bounce_press;
        press_cnt = 0; bounce_press = 0;
        apply_reset();
        btn_n = 1'b0;
        for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
        repeat (3) begin
            btn_n = 1'b1;
            for (int n = 0; n < 8; n++) begin @(posedge clk); #1; if (press) bounce_press++; end
            btn_n = 1'b0;
            for (int n = 0; n < 8; n++) begin @(posedge clk); #1; if (press) bounce_press++; end
        end
        btn_n = 1'b1;
        for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
        btn_n = 1'b0;
        for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
        btn_n = 1'b1;
        for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (press) press_cnt++; end
        tests++; if (bounce_press !== 0) begin fails++; $display("FAIL bounce_press: got %0d expected 0", bounce_press); end
        tests++; if (press_cnt !== 2) begin fails++; $display("FAIL bounce_total_press: got %0d expected 2", press_cnt); end
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL bounce_start: got %b expected 0", start); end
    endtask

    task automatic test_tick_press();
        int press_at, start_at, tick_cnt, tick2_at;
        bit coincide;
        press_at = -1; start_at = -1; tick_cnt = 0; tick2_at = -1; coincide = 0;
        apply_reset();
        for (int n = 1; n <= 1600; n++) begin
            @(posedge clk); #1;
            if (press && press_at < 0) press_at = n;
            if (press && tick) coincide = 1;
            if (tick) begin
                tick_cnt++;
                if (tick_cnt == 2) tick2_at = n;
            end
            if (start && start_at < 0) start_at = n;
            if (n == 477) btn_n = 1'b0;
            if (n == 560) btn_n = 1'b1;
        end
        tests++; if (press_at !== 500) begin fails++; $display("FAIL tp_press_cycle: got %0d expected 500", press_at); end
        tests++; if (coincide !== 1'b1) begin fails++; $display("FAIL tp_coincide: got %b expected 1", coincide); end
        tests++; if (start_at !== 501) begin fails++; $display("FAIL tp_start_cycle: got %0d expected 501", start_at); end
        tests++; if (tick2_at !== 1500) begin fails++; $display("FAIL tp_tick2_cycle: got %0d expected 1500", tick2_at); end
    endtask

    task automatic test_reset_mid();
        int rise_at, press_cnt;
        logic prev;
        rise_at = -1; press_cnt = 0;
        apply_reset();
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (press) press_cnt++;
            if (n == 290) btn_n = 1'b0;
        end
        rst_n = 1'b0;
        btn_n = 1'b1;
        @(posedge clk); #1;
        tests++; if ({slow_clk, tick, start, press} !== 4'b0000) begin fails++; $display("FAIL mid_reset_outputs: got %b expected 0000", {slow_clk, tick, start, press}); end
        rst_n = 1'b1;
        prev = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            if (slow_clk && !prev && rise_at < 0) rise_at = n;
            if (press) press_cnt++;
            prev = slow_clk;
        end
        tests++; if (rise_at !== 500) begin fails++; $display("FAIL mid_reset_rise: got %0d expected 500", rise_at); end
        tests++; if (press_cnt !== 0) begin fails++; $display("FAIL mid_reset_press: got %0d expected 0", press_cnt); end
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL mid_reset_start: got %b expected 0", start); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        btn_n = 1'b1;
        test_reset();
        test_prescaler();
        test_press();
        test_glitch();
        test_bounce();
        test_tick_press();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
